// File: rtl/ntp_clock_axi_regs_if.sv
// AXI4-Lite bus bundle between the PCIe-AXI bridge master port and an NTP clock register file.
interface ntp_clock_axi_regs_if #(
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] axi_awaddr;
    logic [2:0]            axi_awprot;
    logic                  axi_awvalid;
    logic                  axi_awready;
    logic [31:0]           axi_wdata;
    logic [3:0]            axi_wstrb;
    logic                  axi_wvalid;
    logic                  axi_wready;
    logic [1:0]            axi_bresp;
    logic                  axi_bvalid;
    logic                  axi_bready;
    logic [ADDR_WIDTH-1:0] axi_araddr;
    logic [2:0]            axi_arprot;
    logic                  axi_arvalid;
    logic                  axi_arready;
    logic [31:0]           axi_rdata;
    logic [1:0]            axi_rresp;
    logic                  axi_rvalid;
    logic                  axi_rready;

    modport master (
        output axi_awaddr, axi_awprot, axi_awvalid,
        input  axi_awready,
        output axi_wdata, axi_wstrb, axi_wvalid,
        input  axi_wready,
        input  axi_bresp, axi_bvalid,
        output axi_bready,
        output axi_araddr, axi_arprot, axi_arvalid,
        input  axi_arready,
        input  axi_rdata, axi_rresp, axi_rvalid,
        output axi_rready
    );

    modport slave (
        input  axi_awaddr, axi_awprot, axi_awvalid,
        output axi_awready,
        input  axi_wdata, axi_wstrb, axi_wvalid,
        output axi_wready,
        output axi_bresp, axi_bvalid,
        input  axi_bready,
        input  axi_araddr, axi_arprot, axi_arvalid,
        output axi_arready,
        output axi_rdata, axi_rresp, axi_rvalid,
        input  axi_rready
    );
endinterface

// File: rtl/ntp_clock_axi_regs.sv
// AXI4-Lite register file for one NTP clock: identity, control, status,
// coherent 64-bit time snapshot, scratch and time-update counter.
module ntp_clock_axi_regs #(
    parameter int          ADDR_WIDTH   = 5,
    parameter logic [31:0] CORE_NAME    = 32'h6e747063,
    parameter logic [31:0] CORE_VERSION = 32'h00000100
) (
    input  logic                 axi_aclk,
    input  logic                 reset,
    ntp_clock_axi_regs_if.slave  axi,
    input  logic [63:0]          ntp_time,
    input  logic                 ntp_time_upd,
    input  logic                 sync_ok,
    input  logic                 pll_locked,
    output logic [7:0]           ctrl
);

    typedef enum logic [2:0] {
        IDX_NAME    = 3'd0,
        IDX_VERSION = 3'd1,
        IDX_CTRL    = 3'd2,
        IDX_STATUS  = 3'd3,
        IDX_TIME_HI = 3'd4,
        IDX_TIME_LO = 3'd5,
        IDX_SCRATCH = 3'd6,
        IDX_UPD_CNT = 3'd7
    } reg_idx_e;

    logic        aw_got_q, aw_got_d;
    reg_idx_e    aw_idx_q, aw_idx_d;
    logic        w_got_q, w_got_d;
    logic [31:0] w_data_q, w_data_d;
    logic [3:0]  w_strb_q, w_strb_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [31:0] scratch_q, scratch_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] snap_lo_q, snap_lo_d;

    logic        aw_fire, w_fire, ar_fire, commit;
    reg_idx_e    wr_idx, rd_idx;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        unused_ok;

    // Readies are gated by reset so they read 0 while reset is held, not just after the edge.
    assign axi.axi_awready = !reset && !aw_got_q && !bvalid_q;
    assign axi.axi_wready  = !reset && !w_got_q && !bvalid_q;
    assign axi.axi_arready = !reset && !rvalid_q;
    assign axi.axi_bvalid  = bvalid_q;
    assign axi.axi_bresp   = bresp_q;
    assign axi.axi_rvalid  = rvalid_q;
    assign axi.axi_rdata   = rdata_q;
    assign axi.axi_rresp   = '0;
    assign ctrl            = ctrl_q;

    assign unused_ok = ^{axi.axi_awprot, axi.axi_arprot, axi.axi_awaddr[1:0], axi.axi_araddr[1:0]};

    always_comb begin
        aw_fire = axi.axi_awvalid && axi.axi_awready;
        w_fire  = axi.axi_wvalid && axi.axi_wready;
        ar_fire = axi.axi_arvalid && axi.axi_arready;
        wr_idx  = aw_got_q ? aw_idx_q : reg_idx_e'(axi.axi_awaddr[4:2]);
        wr_data = w_got_q ? w_data_q : axi.axi_wdata;
        wr_strb = w_got_q ? w_strb_q : axi.axi_wstrb;
        rd_idx  = reg_idx_e'(axi.axi_araddr[4:2]);
        commit  = (aw_got_q || aw_fire) && (w_got_q || w_fire);

        aw_got_d  = aw_got_q;
        aw_idx_d  = aw_idx_q;
        w_got_d   = w_got_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        ctrl_d    = ctrl_q;
        scratch_d = scratch_q;
        snap_lo_d = snap_lo_q;
        cnt_d     = ntp_time_upd ? cnt_q + 32'd1 : cnt_q;

        if (aw_fire) begin
            aw_got_d = 1'b1;
            aw_idx_d = reg_idx_e'(axi.axi_awaddr[4:2]);
        end
        if (w_fire) begin
            w_got_d  = 1'b1;
            w_data_d = axi.axi_wdata;
            w_strb_d = axi.axi_wstrb;
        end

        // Commit and a pending B are mutually exclusive since readies drop while bvalid is high.
        if (commit) begin
            aw_got_d = 1'b0;
            w_got_d  = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = 2'b10;
            case (wr_idx)
                IDX_CTRL: begin
                    bresp_d = 2'b00;
                    if (wr_strb[0]) ctrl_d = wr_data[7:0];
                end
                IDX_SCRATCH: begin
                    bresp_d = 2'b00;
                    for (int unsigned i = 0; i < 4; i++) begin
                        if (wr_strb[i]) scratch_d[8*i +: 8] = wr_data[8*i +: 8];
                    end
                end
                IDX_UPD_CNT: begin
                    bresp_d = 2'b00;
                    cnt_d   = '0;
                end
                default: ;
            endcase
        end else if (bvalid_q && axi.axi_bready) begin
            bvalid_d = 1'b0;
        end

        if (ar_fire) begin
            rvalid_d = 1'b1;
            case (rd_idx)
                IDX_NAME:    rdata_d = CORE_NAME;
                IDX_VERSION: rdata_d = CORE_VERSION;
                IDX_CTRL:    rdata_d = {24'd0, ctrl_q};
                IDX_STATUS:  rdata_d = {30'd0, pll_locked, sync_ok};
                IDX_TIME_HI: begin
                    rdata_d   = ntp_time[63:32];
                    snap_lo_d = ntp_time[31:0];
                end
                IDX_TIME_LO: rdata_d = snap_lo_q;
                IDX_SCRATCH: rdata_d = scratch_q;
                IDX_UPD_CNT: rdata_d = cnt_q;
            endcase
        end else if (rvalid_q && axi.axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            aw_got_q  <= 1'b0;
            aw_idx_q  <= IDX_NAME;
            w_got_q   <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            ctrl_q    <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            snap_lo_q <= '0;
        end else begin
            aw_got_q  <= aw_got_d;
            aw_idx_q  <= aw_idx_d;
            w_got_q   <= w_got_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            ctrl_q    <= ctrl_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            snap_lo_q <= snap_lo_d;
        end
    end

endmodule
